sr_cmd_debouncer: RTL
=====================

// Module: sr_cmd_debouncer
// PURPOSE
//  Upstream command stage for the SR flip-flop block. Takes two raw, asynchronous,
//  bouncy push-button inputs (set / clear), synchronises and debounces them, and
//  issues clean, mutually exclusive s / r pulses that drive the flip-flop's s,r inputs.
//  Guarantees s=r=1 is never presented downstream; simultaneous requests are flagged.
// PARAMETERS
//  SYNC_STAGES  2   synchroniser depth per button input (>=2)
//  DB_CYCLES    4   consecutive cycles a synced level must differ from debounced state to be accepted (>=2)
//  PULSE_LEN    2   cycles s or r is held high per command (>=1)
//  HOLDOFF      3   lockout cycles after a pulse before next command accepted (>=1)
// PORTS
//  clk       in   1  system clock, all logic on rising edge
//  rst       in   1  asynchronous, active-low reset (0 = reset)
//  set_btn   in   1  raw set button, asynchronous, may bounce
//  clr_btn   in   1  raw clear button, asynchronous, may bounce
//  s         out  1  set command to flip-flop, registered
//  r         out  1  reset command to flip-flop, registered
//  busy      out  1  high while a pulse or holdoff is in progress
//  conflict  out  1  one-cycle pulse: set and clear accepted on the same cycle
//  cmd_cnt   out  8  number of commands issued, wraps 255->0
// BEHAVIOUR
//  Reset (rst=0, async): sync flops, debounced states, counters, FSM -> 0 / IDLE;
//   s=0, r=0, busy=0, conflict=0, cmd_cnt=0. Reset mid-pulse drops outputs at once.
//  Sync: SYNC_STAGES-flop chain per button, reset to 0.
//  Debounce (per input): db_cnt resets to 0 whenever synced==db; when synced!=db,
//   db_cnt increments; when synced!=db and db_cnt==DB_CYCLES-1, db<=synced, db_cnt<=0.
//   Glitch shorter than DB_CYCLES cycles is discarded. Counter width $clog2(DB_CYCLES).
//  Edge detect: req_x = db_x & ~db_x_d (rising edge of debounced level only; release ignored).
//  FSM states IDLE, SET, CLR, HOLD:
//   IDLE: req_set&req_clr -> conflict=1 next cycle, stay IDLE, no count.
//         req_set only -> SET; req_clr only -> CLR; cmd_cnt+1 on the entry edge.
//   SET/CLR: s (resp. r) high for exactly PULSE_LEN cycles, then -> HOLD.
//   HOLD: HOLDOFF cycles, then -> IDLE.
//   Any req arriving outside IDLE is ignored (not queued); button must be released
//   and re-pressed (new debounced rising edge) to issue again.
//  Outputs decoded from registered state: s=(state==SET), r=(state==CLR), busy=(state!=IDLE).
//   s and r never both high. busy high for PULSE_LEN+HOLDOFF cycles per command.
//  Latency: button held steady from before edge 1 -> synced after edge SYNC_STAGES,
//   db after edge SYNC_STAGES+DB_CYCLES, s/r high after edge SYNC_STAGES+DB_CYCLES+1
//   (7 with defaults).
//  cmd_cnt: 8-bit unsigned, wraps silently; conflicts do not count.
// TESTING
//  1 rst=0 then release; both buttons 0 -> s=r=busy=conflict=0, cmd_cnt=0 for 20 cycles.
//  2 set_btn 0->1 held -> s high after edge 7, exactly 2 cycles; busy high 5 cycles;
//    r stays 0; cmd_cnt=1.
//  3 set_btn bounces 1,0,1,0 each 1 cycle then 0 -> no s pulse, cmd_cnt unchanged;
//    3-cycle high glitch also rejected; 4-cycle high accepted.
//  4 set_btn and clr_btn rise on the same cycle -> conflict one cycle at edge 7,
//    s=r=0 throughout, cmd_cnt unchanged.
//  5 set pressed, clr pressed 2 cycles later (during SET) -> only s pulse, clr ignored;
//    clr released/re-pressed after HOLD -> r pulse, cmd_cnt=2.
//  6 rst asserted while s=1 -> s=0, busy=0 immediately (no clock); 256 commands -> cmd_cnt=0.

Source files
------------

// File: rtl/sr_cmd_debouncer.sv
// sr_cmd_debouncer
// Command front end for the SR flip-flop. Two raw push-buttons (set / clear)
// are synchronised, debounced and edge-detected. Each accepted press becomes
// a fixed-length s or r pulse followed by a lockout window. If both buttons
// are accepted on the same cycle, no command is issued and conflict pulses.
// Because s and r are decoded from a single state register, they can never
// be high together.

module sr_cmd_debouncer #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int PULSE_LEN   = 2,
  parameter int HOLDOFF     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_btn,
  input  logic       clr_btn,
  output logic       s,
  output logic       r,
  output logic       busy,
  output logic       conflict,
  output logic [7:0] cmd_cnt
);

  localparam int DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int TMR_MAX = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_CYCLES - 1);
  localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_LEN - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SET  = 2'd1,
    ST_CLR  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // Index 0 carries the set button, index 1 the clear button.
  logic [SYNC_STAGES-1:0]      r_sync_set;
  logic [SYNC_STAGES-1:0]      r_sync_clr;
  logic [1:0]                  w_synced;
  logic [1:0]                  r_db;
  logic [1:0]                  r_db_d;
  logic [1:0][DB_W-1:0]        r_db_cnt;
  logic [1:0]                  w_req;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [TMR_W-1:0]            r_tmr;
  logic [TMR_W-1:0]            w_tmr_nxt;
  logic                        w_cnt_inc;
  logic                        w_conflict_nxt;

  logic                        r_s;
  logic                        r_r;
  logic                        r_busy;
  logic                        r_conflict;
  logic [7:0]                  r_cmd_cnt;

  // Metastability guard: shift each raw button through its own flop chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync_set <= '0;
      r_sync_clr <= '0;
    end else begin
      r_sync_set <= {r_sync_set[SYNC_STAGES-2:0], set_btn};
      r_sync_clr <= {r_sync_clr[SYNC_STAGES-2:0], clr_btn};
    end
  end

  assign w_synced = {r_sync_clr[SYNC_STAGES-1], r_sync_set[SYNC_STAGES-1]};

  // Debounce: accept a new level only after DB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_db     <= 2'b00;
      r_db_d   <= 2'b00;
      r_db_cnt <= '0;
    end else begin
      r_db_d <= r_db;
      for (int i = 0; i < 2; i++) begin
        if (w_synced[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db[i]     <= w_synced[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + {{(DB_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Only a press (debounced rising edge) requests a command; release is ignored.
  assign w_req = r_db & ~r_db_d;

  // State register and pulse/lockout timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
    end
  end

  // Next-state logic; requests are only looked at while idle, never queued.
  always_comb begin
    w_state_nxt    = r_state;
    w_tmr_nxt      = r_tmr;
    w_cnt_inc      = 1'b0;
    w_conflict_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tmr_nxt = '0;
        if (w_req == 2'b11) begin
          w_conflict_nxt = 1'b1;
        end else if (w_req == 2'b01) begin
          w_state_nxt = ST_SET;
          w_cnt_inc   = 1'b1;
        end else if (w_req == 2'b10) begin
          w_state_nxt = ST_CLR;
          w_cnt_inc   = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SET, ST_CLR: begin
        if (r_tmr == PULSE_LAST) begin
          w_state_nxt = ST_HOLD;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr + {{(TMR_W-1){1'b0}}, 1'b1};
        end
      end
      ST_HOLD: begin
        if (r_tmr == HOLD_LAST) begin
          w_state_nxt = ST_IDLE;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr + {{(TMR_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tmr_nxt   = '0;
      end
    endcase
  end

  // Registered outputs, each one tracking the state register cycle for cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_busy     <= 1'b0;
      r_conflict <= 1'b0;
      r_cmd_cnt  <= 8'd0;
    end else begin
      r_s        <= (w_state_nxt == ST_SET);
      r_r        <= (w_state_nxt == ST_CLR);
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_conflict <= w_conflict_nxt;
      if (w_cnt_inc) begin
        r_cmd_cnt <= r_cmd_cnt + 8'd1;
      end else begin
        r_cmd_cnt <= r_cmd_cnt;
      end
    end
  end

  assign s        = r_s;
  assign r        = r_r;
  assign busy     = r_busy;
  assign conflict = r_conflict;
  assign cmd_cnt  = r_cmd_cnt;

endmodule
